// File: rtl/cic_comp_pkg.sv
// Shared definitions for the CIC compensation FIR: default tap count,
// coefficient width and table, and the sequencer state encoding.
package cic_comp_pkg;

  localparam int NTAPS_DEF = 16;
  localparam int COEF_W    = 16;
  localparam int COEF_LEN  = 16;

  typedef logic signed [COEF_W-1:0] coef_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    ROUND = 2'd2,
    HOLD  = 2'd3
  } fir_state_t;

  // Symmetric inverse-sinc style response; taps sum to 43000 so a full-scale DC input saturates.
  localparam coef_t COEF_TABLE [COEF_LEN] = '{
    -16'sd200,   16'sd300,  -16'sd600,   16'sd1200,
    -16'sd2200,  16'sd4000,  16'sd7000,  16'sd12000,
     16'sd12000, 16'sd7000,  16'sd4000, -16'sd2200,
     16'sd1200, -16'sd600,   16'sd300,  -16'sd200
  };

  function automatic coef_t coef_at(input int idx);
    coef_at = (idx >= 0 && idx < COEF_LEN) ? COEF_TABLE[idx] : '0;
  endfunction

endpackage

// File: rtl/comp_coef_rom.sv
// Combinational coefficient lookup for the compensation FIR.
module comp_coef_rom
  import cic_comp_pkg::*;
#(
  parameter int NTAPS = NTAPS_DEF
) (
  input  logic [$clog2(NTAPS)-1:0] addr,
  output logic signed [COEF_W-1:0] data
);

  always_comb begin
    data = coef_at(int'(addr));
  end

endmodule

// File: rtl/cic_comp_fir.sv
// Decimate-by-2 CIC compensation FIR: one serial MAC per tap over a circular
// sample buffer, round/saturate, then hold the result for a ready/valid consumer.
module cic_comp_fir
  import cic_comp_pkg::*;
#(
  parameter int NTAPS = NTAPS_DEF,
  parameter int IN_W  = 19,
  parameter int OUT_W = 16,
  parameter int SHIFT = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             overrun
);

  localparam int AW    = $clog2(NTAPS);
  localparam int PROD_W = IN_W + COEF_W;
  localparam int ACC_W = PROD_W + AW;
  localparam int SUM_W = ACC_W + 1;

  localparam logic [AW-1:0]           LAST_TAP = AW'(NTAPS - 1);
  localparam logic signed [SUM_W-1:0] HALF     = SUM_W'(longint'(1) <<< (SHIFT - 1));
  localparam logic signed [SUM_W-1:0] SAT_HI   = SUM_W'((longint'(1) <<< (OUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_LO   = ~SAT_HI;

  fir_state_t state, state_next;

  logic signed [IN_W-1:0]   samples [NTAPS];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            tap;
  logic [AW-1:0]            rd_addr;
  logic                     phase;
  logic signed [ACC_W-1:0]  acc;
  logic signed [COEF_W-1:0] coef;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [SUM_W-1:0]  rounded;
  logic signed [SUM_W-1:0]  shifted;
  logic signed [OUT_W-1:0]  out_sat;

  logic accept;
  logic is_compute;
  logic handshake;
  logic start_mac;
  logic drop_in;
  logic drop_out;

  comp_coef_rom #(
    .NTAPS (NTAPS)
  ) u_coef_rom (
    .addr (tap),
    .data (coef)
  );

  always_comb begin
    accept     = in_valid && (state == IDLE || state == HOLD);
    is_compute = accept && phase;
    handshake  = (state == HOLD) && out_valid && out_ready;
    start_mac  = is_compute && (state == IDLE || handshake);
    drop_in    = in_valid && (state == MAC || state == ROUND);
    drop_out   = is_compute && (state == HOLD) && !handshake;
  end

  // Tap k reads the sample written k acceptances before the newest one.
  always_comb begin
    rd_addr  = wr_ptr - AW'(1) - tap;
    prod     = samples[rd_addr] * coef;
    prod_ext = {{AW{prod[PROD_W-1]}}, prod};
  end

  always_comb begin
    rounded = {acc[ACC_W-1], acc} + HALF;
    shifted = rounded >>> SHIFT;
    out_sat = shifted[OUT_W-1:0];
    if (shifted > SAT_HI) begin
      out_sat = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (shifted < SAT_LO) begin
      out_sat = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_mac) state_next = MAC;
      MAC:     if (tap == LAST_TAP) state_next = ROUND;
      ROUND:   state_next = HOLD;
      HOLD: begin
        if (start_mac) begin
          state_next = MAC;
        end else if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        samples[i] <= '0;
      end
      wr_ptr <= '0;
      phase  <= 1'b0;
    end else if (accept) begin
      samples[wr_ptr] <= $signed(in_data);
      wr_ptr          <= wr_ptr + AW'(1);
      phase           <= ~phase;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      tap <= '0;
    end else if (start_mac) begin
      acc <= '0;
      tap <= '0;
    end else if (state == MAC) begin
      acc <= acc + prod_ext;
      tap <= tap + AW'(1);
    end
  end

  // out_data only changes in ROUND, so it stays frozen for the whole of HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (state == ROUND) begin
        out_data  <= out_sat;
        out_valid <= 1'b1;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
      if (drop_in || drop_out) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Randomized self-checking bench for cic_comp_fir against a history-array
// reference of the decimating compensation filter.
module tb_cic_comp_fir;
  import cic_comp_pkg::*;

  localparam int NTAPS = 16;
  localparam int IN_W  = 19;
  localparam int OUT_W = 16;
  localparam int SHIFT = 18;
  localparam longint OUT_MAX = (longint'(1) <<< (OUT_W - 1)) - 1;
  localparam longint OUT_MIN = -(longint'(1) <<< (OUT_W - 1));
  localparam longint IN_MAX  = (longint'(1) <<< (IN_W - 1)) - 1;
  localparam longint IN_MIN  = -(longint'(1) <<< (IN_W - 1));

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic             in_valid  = 1'b0;
  logic [IN_W-1:0]  in_data   = '0;
  logic             out_ready = 1'b1;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
  logic             overrun;

  int     total = 0;
  int     bad   = 0;
  longint hist [NTAPS];
  bit     model_phase;
  longint exp_q [$];
  longint last_out = 0;
  longint held;

  always #5 clk = ~clk;

  cic_comp_fir #(
    .NTAPS (NTAPS),
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .overrun   (overrun)
  );

  task automatic checkOutput(input string tag, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Reference: y = sat(round(sum coef[k] * x[n-k] / 2^SHIFT)), one output per two inputs.
  function automatic longint refOut();
    longint acc = 0;
    for (int k = 0; k < NTAPS; k++) begin
      acc += longint'(COEF_TABLE[k]) * hist[k];
    end
    acc = (acc + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    if (acc > OUT_MAX) acc = OUT_MAX;
    if (acc < OUT_MIN) acc = OUT_MIN;
    return acc;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < NTAPS; k++) hist[k] = 0;
    model_phase = 1'b0;
    exp_q.delete();
  endtask

  task automatic modelAccept(input longint v, input bit keep);
    for (int k = NTAPS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = v;
    if (model_phase && keep) exp_q.push_back(refOut());
    model_phase = ~model_phase;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic driveSample(input longint v);
    in_valid = 1'b1;
    in_data  = v[IN_W-1:0];
    tick();
    in_valid = 1'b0;
  endtask

  // Returns one cycle after the compute sample was taken.
  task automatic applyStimulus(input longint a, input longint b, input bit keep);
    driveSample(a);
    modelAccept(a, 1'b1);
    driveSample(b);
    modelAccept(b, keep);
  endtask

  function automatic longint randSample();
    return longint'($urandom_range(0, 32'(IN_MAX - IN_MIN))) + IN_MIN;
  endfunction

  task automatic pairs(input longint a, input longint b, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(a, b, 1'b1);
      idle(19 + int'($urandom_range(0, 3)));
    end
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      last_out = longint'($signed(out_data));
      checkOutput("result_expected", longint'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) checkOutput("out_data", last_out, exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    longint dc_sum = 0;
    modelReset();
    #2 rst = 1'b0;
    idle(3);
    checkOutput("rst_out_valid", longint'(out_valid), 0);
    checkOutput("rst_out_data", longint'($signed(out_data)), 0);
    checkOutput("rst_overrun", longint'(overrun), 0);
    rst = 1'b1;
    tick();

    $display("[TB] impulse");
    applyStimulus(0, IN_MAX, 1'b1);
    idle(16);
    checkOutput("latency_early", longint'(out_valid), 0);
    tick();
    checkOutput("latency_hit", longint'(out_valid), 1);
    idle(3);
    checkOutput("impulse_k0", last_out, longint'(COEF_TABLE[0]));
    pairs(0, 0, 8);

    $display("[TB] dc");
    for (int k = 0; k < NTAPS; k++) dc_sum += longint'(COEF_TABLE[k]);
    pairs(1000, 1000, NTAPS);
    checkOutput("dc_level", last_out, (1000 * dc_sum + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT);

    $display("[TB] saturation");
    pairs(IN_MAX, IN_MAX, NTAPS);
    checkOutput("sat_pos", last_out, 32767);
    pairs(IN_MIN, IN_MIN, NTAPS);
    checkOutput("sat_neg", last_out, -32768);

    $display("[TB] ramp");
    for (int i = 0; i < 3 * NTAPS; i += 2) pairs(longint'(i), longint'(i + 1), 1);

    $display("[TB] random");
    for (int i = 0; i < 20; i++) pairs(randSample(), randSample(), 1);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(randSample(), randSample(), 1'b1);
    idle(20);
    held = exp_q[0];
    checkOutput("bp_valid_first", longint'(out_valid), 1);
    checkOutput("bp_data_first", longint'($signed(out_data)), held);
    checkOutput("bp_overrun_before", longint'(overrun), 0);
    applyStimulus(randSample(), randSample(), 1'b0);
    idle(20);
    checkOutput("bp_valid_held", longint'(out_valid), 1);
    checkOutput("bp_data_held", longint'($signed(out_data)), held);
    checkOutput("bp_overrun_after", longint'(overrun), 1);
    out_ready = 1'b1;
    idle(3);
    pairs(randSample(), randSample(), 2);

    $display("[TB] reset mid-mac");
    applyStimulus(randSample(), randSample(), 1'b0);
    idle(4);
    rst = 1'b0;
    #1;
    checkOutput("midrst_out_valid", longint'(out_valid), 0);
    checkOutput("midrst_overrun", longint'(overrun), 0);
    checkOutput("midrst_out_data", longint'($signed(out_data)), 0);
    modelReset();
    idle(2);
    rst = 1'b1;
    applyStimulus(0, IN_MAX, 1'b1);
    idle(19);
    checkOutput("midrst_impulse_k0", last_out, longint'(COEF_TABLE[0]));
    pairs(0, 0, 7);
    checkOutput("midrst_no_overrun", longint'(overrun), 0);

    $display("[TB] drop during mac");
    applyStimulus(randSample(), randSample(), 1'b1);
    idle(3);
    driveSample(12345);
    idle(18);
    checkOutput("mac_drop_overrun", longint'(overrun), 1);
    pairs(randSample(), randSample(), 3);

    idle(25);
    checkOutput("drain", longint'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cic_comp_fir.md
CIC_COMP_FIR -- requirements
Module: cic_comp_fir

Interface
REQ-001 SHALL have parameter NTAPS, default 16: FIR tap count, an even power of two.
REQ-002 SHALL have parameter IN_W, default 19: input sample width, matching the CIC output.
REQ-003 SHALL have parameter OUT_W, default 16: output sample width.
REQ-004 SHALL have parameter SHIFT, default 18: right-shift applied to the accumulator before rounding.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid, input, 1: one-cycle strobe marking a new CIC sample on in_data.
REQ-008 SHALL have port in_data, input, IN_W: CIC output sample, two's complement.
REQ-009 SHALL have port out_valid, output, 1: out_data holds an unconsumed result.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts out_data when out_ready and out_valid are both high.
REQ-011 SHALL have port out_data, output, OUT_W: compensated, decimated-by-2 sample, two's complement.
REQ-012 SHALL have port overrun, output, 1: sticky flag for a dropped sample or a dropped result.

Function
REQ-013 SHALL store samples in an NTAPS-deep circular buffer; the write pointer advances by 1 per accepted sample and wraps from NTAPS-1 to 0.
REQ-014 SHALL implement FSM states IDLE, MAC, ROUND and HOLD.
REQ-015 SHALL accept in_valid in IDLE and HOLD by writing the sample and toggling a phase bit; the phase bit is 0 after reset.
REQ-016 SHALL treat a sample accepted with the phase bit at 1 before the toggle as a compute sample; in IDLE, a compute sample moves the FSM to MAC.
REQ-017 SHALL, in MAC, perform one signed IN_W x 16 multiply-accumulate per cycle for NTAPS cycles, with the newest sample paired with coef[0], then move to ROUND.
REQ-018 SHALL size the accumulator at IN_W+16+log2(NTAPS) bits (39 at defaults), so that it never wraps.
REQ-019 SHALL, in ROUND, compute out = (acc + 2^(SHIFT-1)) >>> SHIFT, saturate it to [-2^(OUT_W-1), 2^(OUT_W-1)-1], load out_data, set out_valid and move to HOLD.
REQ-020 SHALL, when a compute sample arrives in cycle 0, assert out_valid in cycle NTAPS+2 (18 at defaults).
REQ-021 SHALL, in HOLD, keep out_data stable while out_valid is high; on out_ready it SHALL clear out_valid and return to IDLE in the next cycle.
REQ-022 SHALL, on in_valid during MAC or ROUND, drop the sample, leave the pointer and phase unchanged and set overrun.
REQ-023 SHALL, on a compute sample during HOLD with no same-cycle out_ready, write the sample, skip the computation and set overrun.
REQ-024 SHALL, on a compute sample during HOLD with same-cycle out_ready, complete the handshake and move to MAC.
REQ-025 SHALL clear overrun only by reset.

Reset
REQ-026 SHALL, while rst is low, force the FSM to IDLE, and clear the buffer, write pointer, phase, accumulator, out_data, out_valid and overrun to 0.
REQ-027 SHALL abandon any MAC in progress when reset asserts mid-operation; no stale out_valid may follow reset release.
REQ-028 SHALL accept in_valid from the first clock edge after rst deasserts.

Structure
REQ-029 SHALL take NTAPS default, the coefficient width (16), the coefficient table and the FSM state encoding from shared package cic_comp_pkg.
REQ-030 SHALL read coefficients from sub-module comp_coef_rom: combinational, address log2(NTAPS) bits, 16-bit signed data.

Verification
REQ-031 SHALL cover impulse: in_data=2^18-1 once, then zeros -> out_data = sat(round(coef[k]*(2^18-1)/2^18)) for k=0,2,4..., one result per two inputs.
REQ-032 SHALL cover DC: in_data=1000 constant, out_ready=1 -> after NTAPS inputs, out_data constant = round(1000*sum(coef)/2^18).
REQ-033 SHALL cover saturation: in_data=+2^18-1 constant with positive-sum coefficients -> out_data=32767; in_data=-2^18 constant -> out_data=-32768.
REQ-034 SHALL cover backpressure: out_ready=0 across two compute samples -> out_data unchanged, overrun=1, out_valid stays high.
REQ-035 SHALL cover reset mid-MAC: rst low in cycle 5 after a compute sample -> out_valid=0, overrun=0, out_data=0, and the next impulse response matches REQ-031.
REQ-036 SHALL cover pointer wrap: 3*NTAPS ramp samples 0,1,2... -> every output equals the golden model, including across the pointer wrap.
